// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates N_DEV requesters onto one single-port synchronous RAM. Each
// transaction is three cycles: latch winner (IDLE), perform the RAM operation
// and acknowledge (ACCESS), then release the grant (DONE).
//
// Ports
//   clk       : single clock, rising edge
//   rst_n     : asynchronous active-low reset (RAM contents are kept)
//   dev_req   : per-device request, level-sensitive
//   dev_we    : per-device write enable (1 = write, 0 = read)
//   dev_addr  : packed addresses, device i at [i*ADDR_W +: ADDR_W]
//   dev_di    : packed write data, device i at [i*DATA_W +: DATA_W]
//   dev_gnt   : one-hot grant, held for the whole transaction
//   dev_ack   : one-hot single-cycle completion pulse
//   mem_do    : read data, holds the last read value
//   busy      : high whenever the FSM is not in IDLE
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting; picks a winner and latches its request fields
// ACCESS | one RAM read or write for the latched request, ack issued
// DONE   | grant and ack dropped, return to IDLE
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int N_DEV     = 4,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int PRIO_MODE = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_DEV-1:0]          dev_req,
    input  logic [N_DEV-1:0]          dev_we,
    input  logic [N_DEV*ADDR_W-1:0]   dev_addr,
    input  logic [N_DEV*DATA_W-1:0]   dev_di,
    output logic [N_DEV-1:0]          dev_gnt,
    output logic [N_DEV-1:0]          dev_ack,
    output logic [DATA_W-1:0]         mem_do,
    output logic                      busy
);

    localparam int IDX_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    win_idx;
    logic                win_found;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_di;
    logic                sel_we;
    logic [ADDR_W-1:0]   addr_lat;
    logic [DATA_W-1:0]   di_lat;
    logic                we_lat;
    int                  start_idx;
    int                  scan_idx;

    logic [DATA_W-1:0]   ram [(1 << ADDR_W)];

    // Winner search: rotate from rr_ptr in round-robin mode, from 0 in
    // fixed-priority mode; first requester found wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        start_idx = (PRIO_MODE == 1) ? 0 : int'(rr_ptr);
        for (int k = 0; k < N_DEV; k++) begin
            scan_idx = (start_idx + k) % N_DEV;
            if (!win_found && dev_req[IDX_W'(scan_idx)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(scan_idx);
            end
        end
    end

    // Constant-index mux of the winner's request fields.
    always_comb begin
        sel_addr = '0;
        sel_di   = '0;
        sel_we   = 1'b0;
        for (int k = 0; k < N_DEV; k++) begin
            if (win_idx == IDX_W'(k)) begin
                sel_addr = dev_addr[k*ADDR_W +: ADDR_W];
                sel_di   = dev_di[k*DATA_W +: DATA_W];
                sel_we   = dev_we[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            dev_gnt  <= '0;
            dev_ack  <= '0;
            busy     <= 1'b0;
            mem_do   <= '0;
            rr_ptr   <= '0;
            addr_lat <= '0;
            di_lat   <= '0;
            we_lat   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        addr_lat <= sel_addr;
                        di_lat   <= sel_di;
                        we_lat   <= sel_we;
                        dev_gnt  <= N_DEV'(1) << win_idx;
                        busy     <= 1'b1;
                        state    <= ACCESS;
                        if (PRIO_MODE == 0) begin
                            rr_ptr <= (win_idx == IDX_W'(N_DEV - 1)) ? '0
                                                                     : win_idx + IDX_W'(1);
                        end
                    end
                end
                ACCESS: begin
                    dev_ack <= dev_gnt;
                    if (!we_lat) begin
                        mem_do <= ram[addr_lat];
                    end
                    state <= DONE;
                end
                DONE: begin
                    dev_gnt <= '0;
                    dev_ack <= '0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Reset forces state to IDLE asynchronously, so an aborted write never
    // reaches the array; the array itself has no reset.
    always_ff @(posedge clk) begin
        if (state == ACCESS && we_lat) begin
            ram[addr_lat] <= di_lat;
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: N_DEV, default 4, number of requesting devices (2..8).
REQ-002 Parameters SHALL include: ADDR_W, default 8, address width; internal RAM depth is 2**ADDR_W words.
REQ-003 Parameters SHALL include: DATA_W, default 8, data word width.
REQ-004 Parameters SHALL include: PRIO_MODE, default 0; 0 = round-robin, 1 = fixed priority with lowest index winning.
REQ-005 Ports SHALL be as follows, clock and reset first:
clk  in  1  single clock; all state updates occur on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
dev_req  in  N_DEV  per-device access request, level-sensitive.
dev_we  in  N_DEV  per-device write enable; 1 = write, 0 = read.
dev_addr  in  N_DEV*ADDR_W  packed addresses; device i occupies bits [i*ADDR_W +: ADDR_W].
dev_di  in  N_DEV*DATA_W  packed write data; device i occupies bits [i*DATA_W +: DATA_W].
dev_gnt  out  N_DEV  one-hot grant, held for the whole transaction.
dev_ack  out  N_DEV  one-hot, single-cycle completion pulse.
mem_do  out  DATA_W  read data.
busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-006 The block SHALL contain a single-port synchronous RAM of 2**ADDR_W x DATA_W, accessed only by the FSM.
REQ-007 The FSM SHALL have three states: IDLE, ACCESS and DONE.
REQ-008 IDLE transitions: if any dev_req bit is high, select a winner, latch its addr/di/we, set dev_gnt to the winner and move to ACCESS; otherwise remain in IDLE.
REQ-009 ACCESS transitions: perform exactly one RAM operation on this edge (write dev_di, or read into mem_do), assert dev_ack for the winner and move to DONE.
REQ-010 DONE transitions: deassert dev_ack and dev_gnt and return to IDLE.
REQ-011 Latency: with a request sampled at edge E0, dev_gnt SHALL be high from E0 to E2, dev_ack SHALL be high from E1 to E2, and read data SHALL be valid on mem_do while dev_ack is high.
REQ-012 Throughput SHALL be one transaction per 3 cycles under continuous request.
REQ-013 In round-robin mode, the search SHALL start at index rr_ptr and wrap modulo N_DEV.
REQ-014 After each grant to device i, rr_ptr SHALL become (i+1) mod N_DEV, including wrap from N_DEV-1 to 0.
REQ-015 In PRIO_MODE=1 the lowest-index requester SHALL win and rr_ptr SHALL be unused.
REQ-016 Changes to dev_req, dev_addr, dev_di or dev_we after the latch edge SHALL NOT affect the transaction in flight.
REQ-017 A request dropped mid-transaction SHALL still complete and be acknowledged.
REQ-018 A device holding dev_req high through DONE SHALL be treated as a new request at the next IDLE sample.
REQ-019 mem_do SHALL hold the last read value until the next read; writes SHALL NOT change mem_do.
REQ-020 A read following a write to the same address by any device SHALL return the newly written data.
REQ-021 dev_gnt and dev_ack SHALL each never have more than one bit set.
REQ-022 All outputs SHALL be driven from registers, with no combinational path from inputs to outputs.

Reset
REQ-023 Asserting rst_n low SHALL immediately, without waiting for a clock edge, force: state IDLE, dev_gnt=0, dev_ack=0, busy=0, mem_do=0, rr_ptr=0.
REQ-024 Reset asserted mid-transaction SHALL abort it; a write not yet performed SHALL NOT occur, and no ack SHALL be issued.
REQ-025 RAM contents SHALL NOT be cleared by reset.
REQ-026 After rst_n deasserts, the first rising edge SHALL sample requests normally.

Verification
REQ-027 Write then read: device 0 writes 0xA5 to address 0x10; device 1 then reads 0x10 -> dev_ack[1] pulses one cycle with mem_do=0xA5; gnt and ack latencies match REQ-011.
REQ-028 Round-robin, PRIO_MODE=0, N_DEV=4: all four dev_req held high from reset -> grant order 0,1,2,3,0, with acks spaced 3 cycles apart.
REQ-029 Fixed priority, PRIO_MODE=1: dev_req=4'b1010 held high -> device 1 is granted repeatedly and device 3 is never granted.
REQ-030 Stability: dev_addr[0] is changed from 0x20 to 0x30 during ACCESS of a device-0 write of 0x5A -> address 0x20 holds 0x5A and 0x30 is unchanged.
REQ-031 Reset mid-operation: rst_n is pulled low during ACCESS of a write of 0xFF to 0x40, where 0x40 previously held 0x11 -> outputs are 0 asynchronously and a later read of 0x40 returns 0x11.
REQ-032 Idle and wrap: no requests for 10 cycles -> busy=0 and gnt=0 throughout; then a single request on device N_DEV-1 -> rr_ptr wraps to 0.
